// File: rtl/mux_stim_gen.sv
// Self-running a/b/s stimulus for mux2bit21: 9-step sequence, one step per prescaled tick,
// with debounced pause/resume and single-step buttons; outputs change one cycle after a tick.

module mux_stim_btn #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int DBW = $clog2(DB_CYCLES);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

    logic           sync1;
    logic           sync2;
    logic           stable;
    logic           stable_d;
    logic [DBW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DBW'(1);
            end
        end
    end

    // stable and stable_d both clear on reset, so releasing reset never fakes a press
    assign press = stable & ~stable_d;
endmodule

module mux_stim_gen #(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_step,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic       s,
    output logic [3:0] step,
    output logic       paused
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic          pause_press;
    logic          step_press;
    logic [PW-1:0] pcnt;
    logic          auto_tick;
    logic          tick;

    mux_stim_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_pause (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_pause),
        .press (pause_press)
    );

    mux_stim_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_step (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_step),
        .press (step_press)
    );

    assign auto_tick = ~paused & (pcnt == PRE_MAX);
    // A step press only counts while paused; while running it is dropped
    assign tick      = auto_tick | (paused & step_press);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt   <= '0;
            paused <= 1'b0;
            a      <= 2'd0;
            b      <= 2'd0;
            s      <= 1'b0;
            step   <= 4'd0;
        end else begin
            // Prescaler freezes while paused so resuming finishes the partial interval
            if (!paused) begin
                pcnt <= auto_tick ? '0 : pcnt + PW'(1);
            end
            if (pause_press) begin
                paused <= ~paused;
            end
            if (tick) begin
                case (step)
                    4'd0, 4'd1, 4'd2, 4'd3: a <= step[1:0];
                    4'd4, 4'd5, 4'd6, 4'd7: b <= step[1:0];
                    default:                s <= ~s;
                endcase
                step <= (step == 4'd8) ? 4'd0 : step + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mux_stim_gen.sv
// Randomized bench for mux_stim_gen with a tick-count reference model and literal pins.

module tb_mux_stim_gen;
    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_step = 1'b0;
    logic [1:0] a;
    logic [1:0] b;
    logic       s;
    logic [3:0] step;
    logic       paused;

    int checks = 0;
    int failures = 0;

    mux_stim_gen #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_step  (btn_step),
        .a         (a),
        .b         (b),
        .s         (s),
        .step      (step),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: total ticks since reset, running-cycle count, and per-button
    // "cycles the synchronized level has disagreed with the accepted level".
    int m_ticks;
    int m_run;
    bit m_paused;
    bit m_tick;
    bit m_raw[2];
    bit sy1[2];
    bit sy2[2];
    bit stb[2];
    int dis[2];
    bit prs[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ticks = 0;
            m_run = 0;
            m_paused = 1'b0;
            for (int i = 0; i < 2; i++) begin
                sy1[i] = 1'b0; sy2[i] = 1'b0; stb[i] = 1'b0; dis[i] = 0; prs[i] = 1'b0;
            end
        end else begin
            m_raw[0] = btn_pause;
            m_raw[1] = btn_step;
            m_tick = m_paused ? prs[1] : ((m_run % TD) == TD - 1);
            if (!m_paused) m_run++;
            if (m_tick) m_ticks++;
            if (prs[0]) m_paused = !m_paused;
            for (int i = 0; i < 2; i++) begin
                prs[i] = 1'b0;
                if (sy2[i] != stb[i]) begin
                    dis[i]++;
                    if (dis[i] == DB) begin
                        stb[i] = sy2[i];
                        dis[i] = 0;
                        prs[i] = stb[i];
                    end
                end else begin
                    dis[i] = 0;
                end
                sy2[i] = sy1[i];
                sy1[i] = m_raw[i];
            end
        end
    end

    // After n ticks: full rounds c and position r within the 9-step round
    function automatic void exp_out(input int n, output int ea, output int eb,
                                    output int es, output int est);
        int c = n / 9;
        int r = n % 9;
        est = r;
        es  = c % 2;
        if (r == 0)      ea = (c > 0) ? 3 : 0;
        else if (r <= 4) ea = r - 1;
        else             ea = 3;
        if (r >= 5)      eb = r - 5;
        else             eb = (c > 0) ? 3 : 0;
    endfunction

    always @(negedge clk) begin
        int ea, eb, es, est;
        if (!rst) begin
            exp_out(m_ticks, ea, eb, es, est);
            chk("a", a, ea);
            chk("b", b, eb);
            chk("s", s, es);
            chk("step", step, est);
            chk("paused", paused, m_paused);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_s"}, s, 0);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_paused"}, paused, 0);
    endtask

    task automatic press(input bit which, input int hold, input int after);
        @(negedge clk);
        if (which) btn_step = 1'b1; else btn_pause = 1'b1;
        repeat (hold) @(negedge clk);
        btn_step = 1'b0;
        btn_pause = 1'b0;
        repeat (after) @(negedge clk);
    endtask

    initial begin
        int k;
        int ms;
        int changes;
        logic [3:0] prev;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Free-running: ticks at edges 4, 8, ... after release
        repeat (3) @(posedge clk);
        #1 chk("pin_step_e3", step, 0);
        @(posedge clk);
        #1 chk("pin_step_e4", step, 1);
        repeat (32) @(posedge clk);
        #1;
        chk("pin9_step", step, 0);
        chk("pin9_a", a, 3);
        chk("pin9_b", b, 3);
        chk("pin9_s", s, 1);
        repeat (36) @(posedge clk);
        #1 chk("pin18_s", s, 0);

        // Asynchronous reset mid-cycle at step 5
        k = 0;
        while (step != 4'd5 && k < 200) begin
            @(posedge clk);
            #1 k++;
        end
        chk("wait_step5", step, 5);
        #1 rst = 1'b1;
        #1 chk_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Short glitch must be rejected
        press(1'b0, 1, 10);
        chk("glitch_paused", paused, 0);

        // Clean press: paused rises on the 6th edge after the raw edge
        @(negedge clk);
        btn_pause = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("pause_e5", paused, 0);
        @(posedge clk);
        #1 chk("pause_e6", paused, 1);
        repeat (4) @(negedge clk);
        btn_pause = 1'b0;
        repeat (10) @(negedge clk);

        // Single steps while paused
        ms = m_ticks % 9;
        press(1'b1, 10, 10);
        chk("single_step1", step, (ms + 1) % 9);
        press(1'b1, 10, 10);
        chk("single_step2", step, (ms + 2) % 9);
        chk("still_paused", paused, 1);

        // Resume, then a held step button must not add ticks
        press(1'b0, 8, 10);
        chk("resumed", paused, 0);
        @(negedge clk);
        btn_step = 1'b1;
        prev = step;
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 10) btn_step = 1'b0;
            if (step != prev) changes++;
            prev = step;
        end
        chk("run_tick_count", changes, 10);

        // Random mix of button holds, overlaps and occasional resets
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1 chk_zero("rand_rst");
                @(negedge clk);
                rst = 1'b0;
            end
            @(negedge clk);
            btn_pause = 1'($urandom_range(0, 1));
            btn_step  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) @(negedge clk);
            btn_pause = 1'b0;
            btn_step  = 1'b0;
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
